// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM encoding, iteration count, reset value.
package mdu_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFixup
    } mdu_state_e;

    localparam int unsigned DIV_ITER   = 32;
    localparam logic [31:0] HILO_RESET = 32'h0;
    localparam int unsigned CNT_W      = 6;

    // Absolute value of a two's-complement word when sgn is set, identity otherwise.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Execute/Decode-side request bus and HI/LO result bus of the multiply/divide sequencer.
interface mdu_sequencer_if;

    logic        mult_en_e;
    logic        div_en_e;
    logic        unsigned_instr_e;
    logic        hi_write_e;
    logic        lo_write_e;
    logic [31:0] src_a_e;
    logic [31:0] src_b_e;
    logic        hilo_read_d;
    logic        flush_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        stall_o;
    logic        div0_exc_o;

    modport master (
        output mult_en_e, div_en_e, unsigned_instr_e, hi_write_e, lo_write_e,
        output src_a_e, src_b_e, hilo_read_d, flush_i,
        input  hi_o, lo_o, busy_o, stall_o, div0_exc_o
    );

    modport slave (
        input  mult_en_e, div_en_e, unsigned_instr_e, hi_write_e, lo_write_e,
        input  src_a_e, src_b_e, hilo_read_d, flush_i,
        output hi_o, lo_o, busy_o, stall_o, div0_exc_o
    );

endinterface

// File: rtl/mdu_div_core.sv
// Unsigned restoring shift-subtract divider datapath; one quotient bit per step.
module mdu_div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_sub;

    always_comb begin
        shifted = {rem_q, quo_q[31]};
        ge      = shifted >= {1'b0, dvs_q};
        // When ge holds the true difference is below dvs_q, so 32 bits suffice.
        rem_sub = shifted[31:0] - dvs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= 32'h0;
            quo_q <= 32'h0;
            dvs_q <= 32'h0;
        end else if (load) begin
            rem_q <= 32'h0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (ge) begin
                rem_q <= rem_sub;
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO multiply/divide sequencer with MTHI/MTLO and hazard stall.
// Optional divide-by-zero trap enabled by defining MDU_DIV0_TRAP_EN.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned MULT_LATENCY = 4
) (
    input logic           clk,
    input logic           rst,
    mdu_sequencer_if.slave bus
);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      op_a_q, op_b_q;
    logic             signed_q;
    logic             div0_exc_q;

    logic             busy;
    logic             div0_trap;
    logic             core_load;
    logic             core_step;
    logic             req_signed;
    logic [31:0]      mag_a, mag_b;
    logic [31:0]      quo, rem;
    logic             neg_q;
    logic [31:0]      div_hi, div_lo;
    logic [63:0]      mul_a, mul_b, product;

`ifdef MDU_DIV0_TRAP_EN
    assign div0_trap = (bus.src_b_e == 32'h0);
`else
    assign div0_trap = 1'b0;
`endif

    always_comb begin
        busy       = (state_q != StIdle);
        req_signed = !bus.unsigned_instr_e;
        mag_a      = mag(bus.src_a_e, req_signed);
        mag_b      = mag(bus.src_b_e, req_signed);
        core_load  = (state_q == StIdle) && bus.div_en_e && !bus.flush_i && !div0_trap;
        core_step  = (state_q == StDiv) && !bus.flush_i;

        // Low 64 bits of the product of sign- or zero-extended operands.
        mul_a   = {{32{signed_q & op_a_q[31]}}, op_a_q};
        mul_b   = {{32{signed_q & op_b_q[31]}}, op_b_q};
        product = mul_a * mul_b;

        // A zero divisor keeps the all-ones quotient regardless of dividend sign.
        neg_q  = signed_q && (op_a_q[31] ^ op_b_q[31]) && (op_b_q != 32'h0);
        div_lo = neg_q ? -quo : quo;
        div_hi = (signed_q && op_a_q[31]) ? -rem : rem;
    end

    mdu_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_q       <= HILO_RESET;
            lo_q       <= HILO_RESET;
            op_a_q     <= 32'h0;
            op_b_q     <= 32'h0;
            signed_q   <= 1'b0;
            div0_exc_q <= 1'b0;
        end else begin
            div0_exc_q <= 1'b0;
            if (bus.flush_i) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.div_en_e) begin
                            if (div0_trap) begin
                                div0_exc_q <= 1'b1;
                            end else begin
                                state_q  <= StDiv;
                                cnt_q    <= CNT_W'(DIV_ITER - 1);
                                op_a_q   <= bus.src_a_e;
                                op_b_q   <= bus.src_b_e;
                                signed_q <= req_signed;
                            end
                        end else if (bus.mult_en_e) begin
                            state_q  <= StMul;
                            cnt_q    <= CNT_W'(MULT_LATENCY - 1);
                            op_a_q   <= bus.src_a_e;
                            op_b_q   <= bus.src_b_e;
                            signed_q <= req_signed;
                        end else begin
                            if (bus.hi_write_e) hi_q <= bus.src_a_e;
                            if (bus.lo_write_e) lo_q <= bus.src_a_e;
                        end
                    end
                    StMul: begin
                        if (cnt_q == '0) begin
                            hi_q    <= product[63:32];
                            lo_q    <= product[31:0];
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    StDiv: begin
                        if (cnt_q == '0) begin
                            state_q <= StFixup;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    StFixup: begin
                        hi_q    <= div_hi;
                        lo_q    <= div_lo;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.busy_o     = busy;
    assign bus.div0_exc_o = div0_exc_q;
    assign bus.stall_o    = busy && (bus.mult_en_e || bus.div_en_e || bus.hi_write_e ||
                                     bus.lo_write_e || bus.hilo_read_d);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed scenarios plus random MULT/DIV against
// an arithmetic reference model. Adapts its divide-by-zero checks to MDU_DIV0_TRAP_EN.
module tb_mdu_sequencer;

    localparam int unsigned L = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mdu_sequencer_if bus ();

    mdu_sequencer #(.MULT_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mult_en_e        = 1'b0;
        bus.div_en_e         = 1'b0;
        bus.unsigned_instr_e = 1'b0;
        bus.hi_write_e       = 1'b0;
        bus.lo_write_e       = 1'b0;
        bus.src_a_e          = 32'h0;
        bus.src_b_e          = 32'h0;
        bus.hilo_read_d      = 1'b0;
        bus.flush_i          = 1'b0;
    endtask

    // Reference model: {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit uns);
        longint p;
        if (uns) p = longint'({32'h0, a}) * longint'({32'h0, b});
        else     p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit uns);
        longint qa, qb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (uns) begin
            qa = longint'({32'h0, a});
            qb = longint'({32'h0, b});
        end else begin
            qa = longint'($signed(a));
            qb = longint'($signed(b));
        end
        q = qa / qb;
        r = qa % qb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op_exp(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                              input bit uns, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo, input string tag);
        logic [31:0] old_hi, old_lo;
        bit          early;
        int          n;
        old_hi = bus.hi_o;
        old_lo = bus.lo_o;
        early  = 1'b0;
        n      = 0;
        bus.mult_en_e        = !is_div;
        bus.div_en_e         = is_div;
        bus.unsigned_instr_e = uns;
        bus.src_a_e          = a;
        bus.src_b_e          = b;
        step();
        bus.mult_en_e = 1'b0;
        bus.div_en_e  = 1'b0;
        while (bus.busy_o === 1'b1 && n < 60) begin
            if (bus.hi_o !== old_hi || bus.lo_o !== old_lo) early = 1'b1;
            step();
            n++;
        end
        chk({tag, " latency"}, 32'(n), is_div ? 32'd33 : 32'(L));
        chk({tag, " early_write"}, 32'(early), 32'd0);
        chk({tag, " hi"}, bus.hi_o, exp_hi);
        chk({tag, " lo"}, bus.lo_o, exp_lo);
    endtask

    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input bit uns, input string tag);
        logic [63:0] r;
        r = is_div ? ref_div(a, b, uns) : ref_mul(a, b, uns);
        run_op_exp(is_div, a, b, uns, r[63:32], r[31:0], tag);
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] old_hi, old_lo;
        bit          flag;
        int          n;

        idle_inputs();
        #1 rst = 1'b1;
        #1;
        chk("reset hi", bus.hi_o, 32'h0);
        chk("reset lo", bus.lo_o, 32'h0);
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        chk("reset stall", 32'(bus.stall_o), 32'd0);
        chk("reset div0", 32'(bus.div0_exc_o), 32'd0);
        step();
        rst = 1'b0;
        step();

        // MTHI / MTLO single-cycle writes in IDLE.
        bus.hi_write_e = 1'b1;
        bus.src_a_e    = 32'hA5A5_0001;
        step();
        bus.hi_write_e = 1'b0;
        chk("mthi hi", bus.hi_o, 32'hA5A5_0001);
        bus.lo_write_e = 1'b1;
        bus.src_a_e    = 32'h5A5A_0002;
        step();
        bus.lo_write_e = 1'b0;
        chk("mtlo lo", bus.lo_o, 32'h5A5A_0002);
        chk("mtlo hi_kept", bus.hi_o, 32'hA5A5_0001);

        run_op_exp(1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");

        // DIVU 100/7 with an MFLO in Decode during busy.
        bus.hilo_read_d = 1'b1;
        #1 chk("idle mflo stall", 32'(bus.stall_o), 32'd0);
        bus.hilo_read_d      = 1'b0;
        bus.div_en_e         = 1'b1;
        bus.unsigned_instr_e = 1'b1;
        bus.src_a_e          = 32'd100;
        bus.src_b_e          = 32'd7;
        step();
        bus.div_en_e = 1'b0;
        repeat (3) step();
        bus.hilo_read_d = 1'b1;
        #1 chk("busy mflo stall", 32'(bus.stall_o), 32'd1);
        bus.hilo_read_d = 1'b0;
        #1 chk("busy no_req stall", 32'(bus.stall_o), 32'd0);
        n = 3;
        while (bus.busy_o === 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("divu latency", 32'(n), 32'd33);
        chk("divu lo", bus.lo_o, 32'd14);
        chk("divu hi", bus.hi_o, 32'd2);

        run_op_exp(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run_op_exp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, "div_ovf");

        // MTHI arriving mid-DIV is held off until the divide retires.
        r = ref_div(32'd1000, 32'hFFFF_FFFD, 1'b0);
        bus.div_en_e = 1'b1;
        bus.src_a_e  = 32'd1000;
        bus.src_b_e  = 32'hFFFF_FFFD;
        step();
        bus.div_en_e = 1'b0;
        repeat (5) step();
        bus.hi_write_e = 1'b1;
        bus.src_a_e    = 32'h1234;
        n    = 5;
        flag = 1'b0;
        while (bus.busy_o === 1'b1 && n < 60) begin
            #1 if (bus.stall_o !== 1'b1) flag = 1'b1;
            step();
            n++;
        end
        chk("mthi_div latency", 32'(n), 32'd33);
        chk("mthi_div stall_held", 32'(flag), 32'd0);
        chk("mthi_div div_hi", bus.hi_o, r[63:32]);
        chk("mthi_div div_lo", bus.lo_o, r[31:0]);
        chk("mthi_div released", 32'(bus.stall_o), 32'd0);
        step();
        bus.hi_write_e = 1'b0;
        chk("mthi_div hi", bus.hi_o, 32'h1234);
        chk("mthi_div lo_kept", bus.lo_o, r[31:0]);

        // Flush at iteration 10.
        old_hi = bus.hi_o;
        old_lo = bus.lo_o;
        bus.div_en_e = 1'b1;
        bus.src_a_e  = 32'd987654;
        bus.src_b_e  = 32'd321;
        step();
        bus.div_en_e = 1'b0;
        repeat (9) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush busy", 32'(bus.busy_o), 32'd0);
        flag = 1'b0;
        repeat (40) begin
            if (bus.hi_o !== old_hi || bus.lo_o !== old_lo || bus.busy_o !== 1'b0) flag = 1'b1;
            step();
        end
        chk("flush hilo_kept", 32'(flag), 32'd0);
        bus.div_en_e = 1'b1;
        bus.flush_i  = 1'b1;
        step();
        bus.div_en_e = 1'b0;
        bus.flush_i  = 1'b0;
        chk("flush_start busy", 32'(bus.busy_o), 32'd0);
        run_op(1'b1, 32'd50, 32'd6, 1'b1, "after_flush");

        // Reset at iteration 20.
        bus.div_en_e = 1'b1;
        bus.src_a_e  = 32'hDEAD_BEEF;
        bus.src_b_e  = 32'd13;
        step();
        bus.div_en_e = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        #1;
        chk("midrst hi", bus.hi_o, 32'h0);
        chk("midrst lo", bus.lo_o, 32'h0);
        chk("midrst busy", 32'(bus.busy_o), 32'd0);
        step();
        rst  = 1'b0;
        flag = 1'b0;
        repeat (40) begin
            if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.busy_o !== 1'b0) flag = 1'b1;
            step();
        end
        chk("midrst no_write", 32'(flag), 32'd0);

        // Divide by zero.
        bus.hi_write_e = 1'b1;
        bus.lo_write_e = 1'b1;
        bus.src_a_e    = 32'h0BAD_F00D;
        step();
        bus.hi_write_e = 1'b0;
        bus.lo_write_e = 1'b0;
`ifdef MDU_DIV0_TRAP_EN
        bus.div_en_e = 1'b1;
        bus.src_a_e  = 32'd77;
        bus.src_b_e  = 32'h0;
        step();
        bus.div_en_e = 1'b0;
        chk("div0 exc_pulse", 32'(bus.div0_exc_o), 32'd1);
        chk("div0 busy", 32'(bus.busy_o), 32'd0);
        step();
        chk("div0 exc_end", 32'(bus.div0_exc_o), 32'd0);
        chk("div0 hi_kept", bus.hi_o, 32'h0BAD_F00D);
        chk("div0 lo_kept", bus.lo_o, 32'h0BAD_F00D);
`else
        run_op_exp(1'b1, 32'd77, 32'h0, 1'b1, 32'd77, 32'hFFFF_FFFF, "divu0");
        run_op_exp(1'b1, 32'hFFFF_FF00, 32'h0, 1'b0, 32'hFFFF_FF00, 32'hFFFF_FFFF, "div0_neg");
        chk("div0 exc_tied", 32'(bus.div0_exc_o), 32'd0);
`endif

        // Random MULT/MULTU/DIV/DIVU.
        for (int i = 0; i < 24; i++) begin
            bit          is_div, uns;
            logic [31:0] a, b;
            is_div = 1'($urandom_range(0, 1));
            uns    = 1'($urandom_range(0, 1));
            a      = pick();
            b      = pick();
`ifdef MDU_DIV0_TRAP_EN
            if (is_div && b == 32'h0) b = 32'd1;
`endif
            run_op(is_div, a, b, uns, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The block SHALL have parameter MULT_LATENCY, default 4, meaning the number of edges from MULT/MULTU acceptance to the HI/LO write; legal range 1..8.
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mult_en_e  in  1  MULT/MULTU request in the Execute stage.
- div_en_e  in  1  DIV/DIVU request in the Execute stage.
- unsigned_instr_e  in  1  operands are unsigned when 1.
- hi_write_e  in  1  HI write request (MTHI when no mult_en_e/div_en_e).
- lo_write_e  in  1  LO write request (MTLO when no mult_en_e/div_en_e).
- src_a_e  in  32  rs operand (dividend, multiplicand, MTHI/MTLO data).
- src_b_e  in  32  rt operand (divisor, multiplier).
- hilo_read_d  in  1  MFHI/MFLO in the Decode stage.
- flush_i  in  1  abort the operation in progress.
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.
- busy_o  out  1  an operation is in progress.
- stall_o  out  1  stall request to the hazard unit.
- div0_exc_o  out  1  divide-by-zero pulse (only when MDU_DIV0_TRAP_EN is defined).

Function
REQ-003 The FSM SHALL have states IDLE, MUL, DIV and FIXUP.
REQ-004 In IDLE, a start (mult_en_e or div_en_e with stall_o low) SHALL latch the operands and signedness, load the counter, and enter MUL or DIV.
REQ-005 Both mult_en_e and div_en_e high SHALL be treated as div_en_e only.
REQ-006 MUL SHALL wait MULT_LATENCY-1 edges, then write the 64-bit product {HI,LO} and return to IDLE, so HI/LO update at edge k+MULT_LATENCY for acceptance at edge k.
REQ-007 MULT SHALL produce the two's-complement signed product; MULTU SHALL produce the zero-extended product.
REQ-008 DIV SHALL run 32 restoring shift-subtract iterations on operand magnitudes at edges k+1..k+32, then enter FIXUP.
REQ-009 FIXUP SHALL negate the quotient when the operand signs differ (signed only), give the remainder the dividend's sign, write LO=quotient and HI=remainder at edge k+33, and return to IDLE.
REQ-010 0x80000000 / 0xFFFFFFFF (signed) SHALL yield LO=0x80000000, HI=0 (wrap, no exception).
REQ-011 busy_o SHALL be high exactly in the MUL, DIV and FIXUP states.
REQ-012 stall_o SHALL be combinational: busy_o AND (mult_en_e OR div_en_e OR hi_write_e OR lo_write_e OR hilo_read_d).
REQ-013 MTHI/MTLO in IDLE SHALL write src_a_e to HI/LO at that edge with single-cycle latency, and SHALL be stalled while busy_o is high.
REQ-014 flush_i SHALL force IDLE at the next edge and leave HI/LO unchanged.
REQ-015 flush_i together with a start SHALL win, so no operation starts.
REQ-016 The FIXUP/MUL completion write SHALL take precedence over a same-edge MTHI/MTLO; that case cannot arise because stall_o is high.

Reset
REQ-017 rst SHALL asynchronously force IDLE, clear the counter, set hi_o=lo_o=0 and busy_o=0, and set div0_exc_o=0.
REQ-018 rst asserted mid-operation SHALL discard the operation; no HI/LO write SHALL occur after rst is released.

Configuration
REQ-019 With MDU_DIV0_TRAP_EN defined, a DIV/DIVU with src_b_e=0 SHALL not enter DIV, SHALL pulse div0_exc_o high for one cycle at the acceptance edge, and SHALL leave HI/LO unchanged.
REQ-020 Without MDU_DIV0_TRAP_EN, a divide by zero SHALL run normally and yield LO=0xFFFFFFFF and HI=dividend; div0_exc_o SHALL be tied to 0.

Structure
REQ-021 The shared package SHALL hold the FSM state encoding and the localparams DIV_ITER=32 and HILO_RESET=32'h0.
REQ-022 The shift-subtract datapath (remainder/quotient registers, one iteration per edge) SHALL be sub-module mdu_div_core; FSM, counter and sign fixup SHALL stay in mdu_sequencer.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- MULT 0xFFFFFFFE x 3, signed -> at edge k+4: HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy_o high for 4 cycles.
- DIVU 100 / 7 -> at edge k+33: LO=14, HI=2; stall_o high when an MFLO sits in Decode during busy.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- MTHI 0x1234 issued at cycle k+5 of a DIV -> stalled until IDLE, then HI=0x1234 one edge after release.
- flush_i at DIV iteration 10 -> IDLE next edge, HI/LO keep their old values; rst at iteration 20 -> HI=LO=0, busy_o=0 immediately.
- DIV x / 0 -> with MDU_DIV0_TRAP_EN: one-cycle div0_exc_o, HI/LO unchanged; without it: LO=0xFFFFFFFF, HI=x.
